// File: rtl/slave_responder_array.sv
// slave_responder_array
//   Bank of byte-wide register-file slaves behind the unit address decoder.
//   One shared request/acknowledge FSM serves the lowest selected slave,
//   inserts WAIT_CYCLES wait states, then returns a one-cycle registered ack
//   (and read data for reads). Each slave holds 16 x 8-bit locations.
//
//   Optional feature macro: SLAVE_ADDR_CHECK_EN
//     defined   : addr[7:4] != 0 completes normally but the write is dropped
//                 and a read returns 8'hFF
//     undefined : addr[7:4] ignored, addresses alias modulo 16
//
// Ports
//   clock        in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   sel_en_in    in   [NUM_SLAVES] slave select from decoder (expected one-hot)
//   wr_rd_s_in   in   1 = write, 0 = read
//   addr_in      in   [8] byte address
//   wr_data_in   in   [8] write data
//   rd_data_out  out  [8] read data, non-zero only in the ack cycle
//   ack_out      out  [NUM_SLAVES] per-slave one-cycle acknowledge
//
// States
//   S_IDLE | waiting for any select bit; captures the request
//   S_WAIT | counting wait states; select drop aborts the access
//   S_ACK  | ack / read data presented for one cycle
//   S_HOLD | waiting for the served select to drop before re-arming

module slave_responder_array #(
   parameter int WAIT_CYCLES = 2,
   parameter int NUM_SLAVES  = 6
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [NUM_SLAVES-1:0] sel_en_in,
   input  logic                  wr_rd_s_in,
   input  logic [7:0]            addr_in,
   input  logic [7:0]            wr_data_in,
   output logic [7:0]            rd_data_out,
   output logic [NUM_SLAVES-1:0] ack_out
);

   localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_HOLD} state_t;

   state_t                state, state_nxt;
   logic [IDX_W-1:0]      idx_q, idx_nxt, pick;
   logic                  wr_q, wr_nxt;
   logic [7:0]            addr_q, addr_nxt;
   logic [7:0]            data_q, data_nxt;
   logic [3:0]            cnt, cnt_nxt;
   logic [NUM_SLAVES-1:0] ack_nxt;
   logic [7:0]            rd_nxt;

   logic [IDX_W-1:0]      acc_idx;
   logic                  acc_wr;
   logic [7:0]            acc_addr;
   logic [7:0]            acc_data;
   logic                  enter_ack;
   logic                  addr_ok;
   logic                  mem_we;
   logic [7:0]            mem_rd;

   logic [7:0]            mem [NUM_SLAVES][16];

   // lowest set select bit wins
   always_comb begin
      pick = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if (sel_en_in[i]) pick = IDX_W'(i);
      end
   end

   // With zero wait states the access completes on the capture edge, so the
   // live decoder inputs are used in IDLE and the captured copy otherwise.
   always_comb begin
      if (state == S_IDLE) begin
         acc_idx  = pick;
         acc_wr   = wr_rd_s_in;
         acc_addr = addr_in;
         acc_data = wr_data_in;
      end else begin
         acc_idx  = idx_q;
         acc_wr   = wr_q;
         acc_addr = addr_q;
         acc_data = data_q;
      end
   end

`ifdef SLAVE_ADDR_CHECK_EN
   assign addr_ok = (acc_addr[7:4] == 4'h0);
`else
   // upper address bits alias away in this build
   logic unused_addr_hi;
   assign addr_ok        = 1'b1;
   assign unused_addr_hi = ^acc_addr[7:4];
`endif

   assign mem_rd = mem[acc_idx][acc_addr[3:0]];

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx_q;
      wr_nxt    = wr_q;
      addr_nxt  = addr_q;
      data_nxt  = data_q;
      cnt_nxt   = cnt;
      enter_ack = 1'b0;
      case (state)
         S_IDLE: begin
            if (|sel_en_in) begin
               idx_nxt  = pick;
               wr_nxt   = wr_rd_s_in;
               addr_nxt = addr_in;
               data_nxt = wr_data_in;
               if (WAIT_CYCLES == 0) begin
                  cnt_nxt   = 4'd0;
                  enter_ack = 1'b1;
                  state_nxt = S_ACK;
               end else begin
                  cnt_nxt   = 4'(WAIT_CYCLES);
                  state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (!sel_en_in[idx_q]) begin
               cnt_nxt   = 4'd0;
               state_nxt = S_IDLE;
            end else if (cnt <= 4'd1) begin
               cnt_nxt   = 4'd0;
               enter_ack = 1'b1;
               state_nxt = S_ACK;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         S_ACK:  state_nxt = S_HOLD;
         S_HOLD: begin
            if (!sel_en_in[idx_q]) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs are registered on the edge entering ACK; the read samples
   // storage as it stood before that edge.
   always_comb begin
      ack_nxt          = '0;
      ack_nxt[acc_idx] = enter_ack;
      rd_nxt           = 8'h00;
      if (enter_ack && !acc_wr) rd_nxt = addr_ok ? mem_rd : 8'hFF;
      mem_we = enter_ack && acc_wr && addr_ok;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         idx_q       <= '0;
         wr_q        <= 1'b0;
         addr_q      <= 8'h00;
         data_q      <= 8'h00;
         cnt         <= 4'd0;
         ack_out     <= '0;
         rd_data_out <= 8'h00;
      end else begin
         state       <= state_nxt;
         idx_q       <= idx_nxt;
         wr_q        <= wr_nxt;
         addr_q      <= addr_nxt;
         data_q      <= data_nxt;
         cnt         <= cnt_nxt;
         ack_out     <= ack_nxt;
         rd_data_out <= rd_nxt;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < NUM_SLAVES; s++) begin
            for (int a = 0; a < 16; a++) mem[s][a] <= 8'h00;
         end
      end else if (mem_we) begin
         mem[acc_idx][acc_addr[3:0]] <= acc_data;
      end
   end

endmodule

// File: tb/tb_slave_responder_array.sv
// Testbench for slave_responder_array: directed scenarios plus random
// accesses checked against an array-based model of the slave storage.
module tb_slave_responder_array;

   localparam int W = 2;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [5:0] sel_en;
   logic       wr_rd;
   logic [7:0] addr, wdata, rd_data;
   logic [5:0] ack;

   logic [5:0] sel_en0;
   logic       wr_rd0;
   logic [7:0] addr0, wdata0, rd_data0;
   logic [5:0] ack0;

   int n_total = 0;
   int n_pass  = 0;

   logic [7:0] mem_m [6][16];

   always #5 clock = ~clock;

   slave_responder_array #(.WAIT_CYCLES(W), .NUM_SLAVES(6)) u_dut (
      .clock(clock), .reset_n(reset_n), .sel_en_in(sel_en), .wr_rd_s_in(wr_rd),
      .addr_in(addr), .wr_data_in(wdata), .rd_data_out(rd_data), .ack_out(ack));

   slave_responder_array #(.WAIT_CYCLES(0), .NUM_SLAVES(6)) u_dut_w0 (
      .clock(clock), .reset_n(reset_n), .sel_en_in(sel_en0), .wr_rd_s_in(wr_rd0),
      .addr_in(addr0), .wr_data_in(wdata0), .rd_data_out(rd_data0), .ack_out(ack0));

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
   endtask

   function automatic int lowest(input logic [5:0] s);
      for (int i = 0; i < 6; i++) if (s[i]) return i;
      return 0;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 16; j++) mem_m[i][j] = 8'h00;
   endtask

   // Called at a negedge with the FSM idle. Request is captured at the next
   // posedge E0; ack expected in the cycle after E0+W. Decoder inputs are
   // scrambled after capture to confirm the captured request is used.
   task automatic do_access(input logic [5:0] s, input logic w, input logic [7:0] a,
                            input logic [7:0] d, input string tag);
      int         k;
      logic       hi_bad;
      logic [5:0] exp_ack;
      logic [7:0] exp_rd;
      k      = lowest(s);
      hi_bad = 1'b0;
`ifdef SLAVE_ADDR_CHECK_EN
      hi_bad = (a[7:4] != 4'h0);
`endif
      exp_ack = 6'(1) << k;
      exp_rd  = w ? 8'h00 : (hi_bad ? 8'hFF : mem_m[k][a[3:0]]);
      sel_en = s; wr_rd = w; addr = a; wdata = d;
      for (int c = 0; c <= W + 1; c++) begin
         @(negedge clock);
         check({tag, "_ack"}, {2'b00, ack}, (c == W) ? {2'b00, exp_ack} : 8'h00);
         check({tag, "_rd"}, rd_data, (c == W) ? exp_rd : 8'h00);
         if (c == 0) begin
            wr_rd = 1'($urandom);
            addr  = 8'($urandom);
            wdata = 8'($urandom);
         end
      end
      sel_en = '0;
      if (w && !hi_bad) mem_m[k][a[3:0]] = d;
      @(negedge clock);
      check({tag, "_idle_ack"}, {2'b00, ack}, 8'h00);
   endtask

   initial begin
      logic [5:0] rs;
      logic [7:0] ra;
      int         n_pulse, n_other;

      reset_n = 1'b0;
      sel_en = '0; wr_rd = 1'b0; addr = 8'h00; wdata = 8'h00;
      sel_en0 = '0; wr_rd0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00;
      clear_model();
      repeat (3) @(negedge clock);
      check("reset_ack", {2'b00, ack}, 8'h00);
      check("reset_rd", rd_data, 8'h00);
      check("reset_ack_w0", {2'b00, ack0}, 8'h00);
      check("reset_rd_w0", rd_data0, 8'h00);
      reset_n = 1'b1;

      // basic write / read-back / other-slave isolation
      do_access(6'b000100, 1'b1, 8'h05, 8'hA5, "wr_s2");
      do_access(6'b000100, 1'b0, 8'h05, 8'h00, "rd_s2");
      do_access(6'b001000, 1'b0, 8'h05, 8'h00, "rd_s3");

      // abort: select dropped after one edge in WAIT
      sel_en = 6'b000001; wr_rd = 1'b0; addr = 8'h05;
      @(negedge clock);
      check("abort_ack0", {2'b00, ack}, 8'h00);
      sel_en = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("abort_ack", {2'b00, ack}, 8'h00);
         check("abort_rd", rd_data, 8'h00);
      end
      do_access(6'b000001, 1'b1, 8'h07, 8'h5A, "post_abort_wr");
      do_access(6'b000001, 1'b0, 8'h07, 8'h00, "post_abort_rd");

      // multi-hot select: lowest index only
      do_access(6'b010010, 1'b1, 8'h01, 8'h3C, "multi_wr");
      do_access(6'b010000, 1'b0, 8'h01, 8'h00, "multi_rd_s4");
      do_access(6'b000010, 1'b0, 8'h01, 8'h00, "multi_rd_s1");

      // reset during the ack cycle of a read drops outputs at once
      sel_en = 6'b000010; wr_rd = 1'b0; addr = 8'h01;
      for (int c = 0; c <= W; c++) @(negedge clock);
      check("rst_ack_pre", {2'b00, ack}, 8'h02);
      check("rst_rd_pre", rd_data, 8'h3C);
      #1 reset_n = 1'b0;
      #1;
      check("rst_ack_now", {2'b00, ack}, 8'h00);
      check("rst_rd_now", rd_data, 8'h00);
      clear_model();
      sel_en = '0;
      @(negedge clock);
      reset_n = 1'b1;

      // reset during WAIT of a write: write is lost
      sel_en = 6'b001000; wr_rd = 1'b1; addr = 8'h09; wdata = 8'h77;
      @(negedge clock);
      check("rstw_wait_ack", {2'b00, ack}, 8'h00);
      #2 reset_n = 1'b0;
      #1;
      check("rstw_ack", {2'b00, ack}, 8'h00);
      check("rstw_rd", rd_data, 8'h00);
      sel_en = '0;
      @(negedge clock);
      reset_n = 1'b1;
      do_access(6'b001000, 1'b0, 8'h09, 8'h00, "rstw_rd_s3");
      do_access(6'b000010, 1'b0, 8'h01, 8'h00, "rstw_rd_s1");
      do_access(6'b000100, 1'b0, 8'h05, 8'h00, "rstw_rd_s2");

      // upper address bits
      do_access(6'b000010, 1'b1, 8'h13, 8'h11, "ac_wr13");
      do_access(6'b000010, 1'b0, 8'h13, 8'h00, "ac_rd13");
      do_access(6'b000010, 1'b0, 8'h03, 8'h00, "ac_rd03");

      // random traffic
      for (int n = 0; n < 40; n++) begin
         rs = 6'($urandom_range(1, 63));
         ra = 8'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) ra[7:4] = 4'($urandom_range(1, 15));
         do_access(rs, 1'($urandom), ra, 8'($urandom), "rand");
      end

      // held select with zero wait states: exactly one pulse
      sel_en0 = 6'b100000; wr_rd0 = 1'b0; addr0 = 8'h02;
      n_pulse = 0; n_other = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (i == 0) begin
            check("held_first_ack", {2'b00, ack0}, 8'h20);
            check("held_first_rd", rd_data0, 8'h00);
         end
         if (ack0[5]) n_pulse++;
         if (ack0[4:0] != 5'd0) n_other++;
      end
      check("held_pulses", 8'(n_pulse), 8'd1);
      check("held_other", 8'(n_other), 8'd0);
      sel_en0 = '0;
      @(negedge clock);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
